// File: rtl/vx_fp_rsp_collect_pkg.sv
// Shared FPU response definitions: IEEE exception flag record and the width of
// one buffered response payload {has_fflags, fflags[LANES], result[LANES], tag}.
package vx_fp_rsp_collect_pkg;

    localparam int unsigned FFLAGS_BITS = 5;

    // Bit 4 (MSB) .. bit 0: invalid, divide-by-zero, overflow, underflow, inexact.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    function automatic int unsigned payload_width(input int unsigned tagw,
                                                  input int unsigned lanes);
        return tagw + lanes * (32 + FFLAGS_BITS) + 1;
    endfunction

endpackage

// File: rtl/vx_fp_rsp_fifo.sv
// Per-source response buffer: circular FIFO with count-based full/empty.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, data_i    write request and data (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   data_o            current head entry
//   full_o, empty_o   occupancy flags
module vx_fp_rsp_fifo #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DATAW-1:0] data_i,
    output logic [DATAW-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is payload only; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vx_fp_rsp_collect.sv
// Collects responses from NUM_SRC FP cores into one registered writeback stream.
// Each source feeds its own elastic buffer; buffered heads are merged round-robin
// into an output register. Lane fflags are masked by has_fflags and OR-reduced.
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   valid_in/ready_in                   per-source handshake (ready from buffer state)
//   tag_in/result_in/has_fflags_in/fflags_in   per-source payload
//   valid_out/ready_out                 merged writeback handshake
//   tag_out/result_out/has_fflags_out/fflags_out   registered merged payload
//   fflags_merged                       OR of fflags_out over all lanes
module vx_fp_rsp_collect
    import vx_fp_rsp_collect_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned TAGW      = 1,
    parameter int unsigned LANES     = 1,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic    [NUM_SRC-1:0]                valid_in,
    output logic    [NUM_SRC-1:0]                ready_in,
    input  logic    [NUM_SRC-1:0][TAGW-1:0]      tag_in,
    input  logic    [NUM_SRC-1:0][LANES-1:0][31:0] result_in,
    input  logic    [NUM_SRC-1:0]                has_fflags_in,
    input  fflags_t [NUM_SRC-1:0][LANES-1:0]     fflags_in,
    output logic                                 valid_out,
    input  logic                                 ready_out,
    output logic    [TAGW-1:0]                   tag_out,
    output logic    [LANES-1:0][31:0]            result_out,
    output logic                                 has_fflags_out,
    output fflags_t [LANES-1:0]                  fflags_out,
    output fflags_t                              fflags_merged
);

    localparam int unsigned DataW = payload_width(TAGW, LANES);
    localparam int unsigned SrcW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]            full, empty, pop;
    logic [NUM_SRC-1:0][DataW-1:0] push_data, head_data;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_data[i] = {has_fflags_in[i], fflags_in[i], result_in[i], tag_in[i]};
        // Depends only on buffer occupancy and reset, never on ready_out.
        assign ready_in[i]  = reset & ~full[i];

        vx_fp_rsp_fifo #(
            .DATAW (DataW),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (valid_in[i] & ready_in[i]),
            .pop_i   (pop[i]),
            .data_i  (push_data[i]),
            .data_o  (head_data[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    logic                         valid_out_q;
    logic [SrcW-1:0]              rr_q, rr_d;
    logic                         load, found, grant;
    logic [SrcW-1:0]              idx, gnt_idx;
    logic [TAGW-1:0]              h_tag, tag_q;
    logic [LANES-1:0][31:0]       h_res, res_q;
    logic                         h_has, has_q;
    fflags_t [LANES-1:0]          h_ff, ff_q;
    logic [FFLAGS_BITS-1:0]       ff_acc;

    // Round-robin: first non-empty buffer at or after rr_q.
    always_comb begin
        load    = !valid_out_q || ready_out;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = SrcW'((32'(rr_q) + k) % NUM_SRC);
            if (!found && !empty[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        grant = load && found;
        pop   = '0;
        rr_d  = rr_q;
        if (grant) begin
            pop[gnt_idx] = 1'b1;
            rr_d         = SrcW'((32'(gnt_idx) + 1) % NUM_SRC);
        end
        {h_has, h_ff, h_res, h_tag} = head_data[gnt_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q <= 1'b0;
            rr_q        <= '0;
        end else begin
            rr_q <= rr_d;
            if (load) begin
                valid_out_q <= grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_q <= h_tag;
            res_q <= h_res;
            has_q <= h_has;
            for (int unsigned l = 0; l < LANES; l++) begin
                ff_q[l] <= h_has ? h_ff[l] : '0;
            end
        end
    end

    always_comb begin
        ff_acc = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            ff_acc = ff_acc | ff_q[l];
        end
        fflags_merged = ff_acc;
    end

    assign valid_out      = valid_out_q;
    assign tag_out        = tag_q;
    assign result_out     = res_q;
    assign has_fflags_out = has_q;
    assign fflags_out     = ff_q;

endmodule

// File: tb/tb_vx_fp_rsp_collect.sv
module tb_vx_fp_rsp_collect;
    import vx_fp_rsp_collect_pkg::*;

    localparam int NS = 2;
    localparam int TW = 4;
    localparam int LN = 2;
    localparam int BD = 2;

    logic                         clk, reset;
    logic    [NS-1:0]             valid_in, ready_in, has_fflags_in;
    logic    [NS-1:0][TW-1:0]     tag_in;
    logic    [NS-1:0][LN-1:0][31:0] result_in;
    fflags_t [NS-1:0][LN-1:0]     fflags_in;
    logic                         valid_out, ready_out, has_fflags_out;
    logic    [TW-1:0]             tag_out;
    logic    [LN-1:0][31:0]       result_out;
    fflags_t [LN-1:0]             fflags_out;
    fflags_t                      fflags_merged;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [TW-1:0]       tag;
        logic [LN-1:0][31:0] res;
        logic                has;
        logic [LN-1:0][4:0]  ff;
    } ent_t;

    ent_t mq [NS][$];

    vx_fp_rsp_collect #(
        .NUM_SRC   (NS),
        .TAGW      (TW),
        .LANES     (LN),
        .BUF_DEPTH (BD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .tag_in         (tag_in),
        .result_in      (result_in),
        .has_fflags_in  (has_fflags_in),
        .fflags_in      (fflags_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .tag_out        (tag_out),
        .result_out     (result_out),
        .has_fflags_out (has_fflags_out),
        .fflags_out     (fflags_out),
        .fflags_merged  (fflags_merged)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        valid_in      = '0;
        has_fflags_in = '0;
        tag_in        = '0;
        result_in     = '0;
        fflags_in     = '0;
        ready_out     = 1'b0;
    endtask

    // Ends one time unit after a rising edge plus one; callers continue with @(posedge)#1.
    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL rst_valid_out: got %b want 0", valid_out);
        else n_pass++;
        n_checks++;
        if (ready_in !== 2'b00) $display("FAIL rst_ready_in: got %b want 00", ready_in);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_in !== 2'b11) $display("FAIL rel_ready_in: got %b want 11", ready_in);
        else n_pass++;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL rel_valid_out: got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_single();
        test_reset();
        @(posedge clk); #1;
        ready_out       = 1'b1;
        valid_in[0]     = 1'b1;
        tag_in[0]       = 4'd1;
        result_in[0][0] = 32'h3F80_0000;
        result_in[0][1] = 32'h0;
        @(posedge clk); #1;
        valid_in = '0;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL single_e0: valid_out got %b want 0", valid_out);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b1 || tag_out !== 4'd1 || result_out[0] !== 32'h3F80_0000)
            $display("FAIL single_e1: valid %b tag %h res %h want 1 1 3f800000",
                     valid_out, tag_out, result_out[0]);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL single_e2: valid_out got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] exp_tag;
        test_reset();
        @(posedge clk); #1;
        ready_out = 1'b1;
        valid_in  = 2'b11;
        tag_in[0] = 4'd0;
        tag_in[1] = 4'd1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c >= 2) begin
                exp_tag = (c % 2 == 0) ? 4'd0 : 4'd1;
                n_checks++;
                if (valid_out !== 1'b1 || tag_out !== exp_tag)
                    $display("FAIL rr_cycle%0d: valid %b tag %h want 1 %h",
                             c, valid_out, tag_out, exp_tag);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int  next_tag;
        int  got;
        logic acc;
        test_reset();
        @(posedge clk); #1;
        ready_out = 1'b0;
        next_tag  = 0;
        for (int c = 0; c < 6; c++) begin
            valid_in[0] = 1'b1;
            tag_in[0]   = TW'(next_tag);
            acc         = ready_in[0];
            @(posedge clk); #1;
            if (acc) next_tag++;
            if (c >= 1) begin
                n_checks++;
                if (valid_out !== 1'b1 || tag_out !== 4'd0)
                    $display("FAIL bp_hold%0d: valid %b tag %h want 1 0", c, valid_out, tag_out);
                else n_pass++;
            end
        end
        n_checks++;
        if (next_tag !== 3) $display("FAIL bp_accepts: got %0d want 3", next_tag);
        else n_pass++;
        n_checks++;
        if (ready_in[0] !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", ready_in[0]);
        else n_pass++;
        ready_out = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (valid_out) begin
                n_checks++;
                if (tag_out !== TW'(got)) $display("FAIL bp_order%0d: got %h want %h",
                                                   got, tag_out, TW'(got));
                else n_pass++;
                got++;
            end
            if (next_tag < 6) begin
                valid_in[0] = 1'b1;
                tag_in[0]   = TW'(next_tag);
                acc         = ready_in[0];
            end else begin
                valid_in[0] = 1'b0;
                acc         = 1'b0;
            end
            @(posedge clk); #1;
            if (acc) next_tag++;
        end
        n_checks++;
        if (got !== 6) $display("FAIL bp_count: got %0d want 6", got);
        else n_pass++;
        n_checks++;
        if (valid_out !== 1'b0) $display("FAIL bp_no_dup: valid_out got %b want 0", valid_out);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_fflags();
        for (int h = 1; h >= 0; h--) begin
            test_reset();
            @(posedge clk); #1;
            ready_out        = 1'b1;
            valid_in[0]      = 1'b1;
            has_fflags_in[0] = h[0];
            fflags_in[0][0]  = 5'b01000;
            fflags_in[0][1]  = 5'b00001;
            @(posedge clk); #1;
            valid_in = '0;
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b1 || has_fflags_out !== h[0])
                $display("FAIL ff_valid_h%0d: valid %b has %b want 1 %b",
                         h, valid_out, has_fflags_out, h[0]);
            else n_pass++;
            n_checks++;
            if (fflags_out !== (h ? 10'b00001_01000 : 10'b0))
                $display("FAIL ff_lanes_h%0d: got %h want %h", h, fflags_out,
                         (h ? 10'b00001_01000 : 10'b0));
            else n_pass++;
            n_checks++;
            if (fflags_merged !== (h ? 5'b01001 : 5'b0))
                $display("FAIL ff_merged_h%0d: got %b want %b", h, fflags_merged,
                         (h ? 5'b01001 : 5'b0));
            else n_pass++;
            clear_inputs();
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        @(posedge clk); #1;
        ready_out = 1'b0;
        for (int c = 0; c < 3; c++) begin
            valid_in[0] = 1'b1;
            tag_in[0]   = TW'(c + 5);
            @(posedge clk); #1;
        end
        valid_in = '0;
        n_checks++;
        if (valid_out !== 1'b1 || ready_in[0] !== 1'b0)
            $display("FAIL mid_pre: valid %b ready0 %b want 1 0", valid_out, ready_in[0]);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || ready_in !== 2'b00)
            $display("FAIL mid_async: valid %b ready %b want 0 00", valid_out, ready_in);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_in !== 2'b11) $display("FAIL mid_release: ready %b want 11", ready_in);
        else n_pass++;
        ready_out = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== 1'b0) $display("FAIL mid_stale%0d: valid %b want 0", c, valid_out);
            else n_pass++;
        end
        clear_inputs();
    endtask

    // Transaction-level model: each source is a bounded queue, the writeback slot is a
    // single entry refilled from the next non-empty queue in rotating order.
    task automatic test_random(input int n);
        ent_t        cur [NS];
        logic        pend [NS];
        logic        mready [NS];
        ent_t        mo;
        logic        mv;
        int          rr;
        int          sel;
        logic [LN-1:0][4:0] exp_ff;
        logic [4:0]  exp_m;
        test_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            mq[i].delete();
            pend[i] = 1'b0;
        end
        mv = 1'b0;
        mo = '0;
        rr = 0;
        for (int c = 0; c < n; c++) begin
            ready_out = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NS; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    cur[i].tag = TW'($urandom_range(0, 15));
                    for (int l = 0; l < LN; l++) begin
                        cur[i].res[l] = $urandom;
                        cur[i].ff[l]  = 5'($urandom_range(0, 31));
                    end
                    cur[i].has = 1'($urandom_range(0, 1));
                    pend[i] = 1'b1;
                end
                valid_in[i]      = pend[i];
                tag_in[i]        = cur[i].tag;
                result_in[i]     = cur[i].res;
                has_fflags_in[i] = cur[i].has;
                fflags_in[i]     = cur[i].ff;
                mready[i]        = (mq[i].size() < BD);
                n_checks++;
                if (ready_in[i] !== mready[i])
                    $display("FAIL rnd_ready%0d_c%0d: got %b want %b", i, c, ready_in[i], mready[i]);
                else n_pass++;
            end
            if (!mv || ready_out) begin
                sel = -1;
                for (int k = 0; k < NS; k++) begin
                    if (sel < 0 && mq[(rr + k) % NS].size() > 0) sel = (rr + k) % NS;
                end
                if (sel >= 0) begin
                    mo = mq[sel].pop_front();
                    mv = 1'b1;
                    rr = (sel + 1) % NS;
                end else begin
                    mv = 1'b0;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (pend[i] && mready[i]) begin
                    mq[i].push_back(cur[i]);
                    pend[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
            n_checks++;
            if (valid_out !== mv) $display("FAIL rnd_valid_c%0d: got %b want %b", c, valid_out, mv);
            else n_pass++;
            if (mv) begin
                exp_ff = mo.has ? mo.ff : '0;
                exp_m  = '0;
                for (int l = 0; l < LN; l++) exp_m = exp_m | exp_ff[l];
                n_checks++;
                if (tag_out !== mo.tag || result_out !== mo.res || has_fflags_out !== mo.has)
                    $display("FAIL rnd_payload_c%0d: tag %h res %h has %b want %h %h %b",
                             c, tag_out, result_out, has_fflags_out, mo.tag, mo.res, mo.has);
                else n_pass++;
                n_checks++;
                if (fflags_out !== exp_ff || fflags_merged !== exp_m)
                    $display("FAIL rnd_fflags_c%0d: lanes %h merged %b want %h %b",
                             c, fflags_out, fflags_merged, exp_ff, exp_m);
                else n_pass++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fflags();
        test_reset_mid();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
